// File: rtl/idu_pkg.sv
// Shared RV32I decode encodings and the IDU-to-EXU bundle type. The execute stage uses
// the same encodings, so values here must not be reordered.
package idu_pkg;
  localparam int CPU_WIDTH           = 32;
  localparam int REG_ADDR_WIDTH      = 5;
  localparam int DATA_MEM_ADDR_WIDTH = 32;
  localparam int ALU_OP_WIDTH        = 4;
  localparam int BRAN_WIDTH          = 3;
  localparam int JUMP_WIDTH          = 2;
  localparam int MEM_OP_WIDTH        = 3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // mem_op carries funct3 unchanged: B/H/W signed, BU/HU unsigned
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_B  = 3'b000;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_H  = 3'b001;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_W  = 3'b010;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_BU = 3'b100;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_HU = 3'b101;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQU
  } alu_op_e;

  typedef enum logic [BRAN_WIDTH-1:0] {
    BRAN_NONE, BRAN_BEQ, BRAN_BNE, BRAN_BLT, BRAN_BGE, BRAN_BLTU, BRAN_BGEU
  } bran_e;

  typedef enum logic [JUMP_WIDTH-1:0] {JUMP_NONE, JUMP_JAL, JUMP_JALR} jump_e;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]           pc;
    logic [CPU_WIDTH-1:0]           inst;
    bran_e                          branch;
    jump_e                          jump;
    logic                           reg_wen;
    logic [REG_ADDR_WIDTH-1:0]      reg_waddr;
    logic                           mem_wen;
    logic                           mem_ren;
    logic [DATA_MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_MEM_ADDR_WIDTH-1:0] mem_raddr;
    logic                           mem2reg;
    logic [MEM_OP_WIDTH-1:0]        mem_op;
    alu_op_e                        alu_op;
    logic [CPU_WIDTH-1:0]           alu_src1;
    logic [CPU_WIDTH-1:0]           alu_src2;
    logic                           illegal;
  } idu_bundle_t;

  function automatic alu_op_e alu_of_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I decoder: instruction, PC and register data in, EXU bundle out.
// Branch and jump targets are rebuilt in EXU from the forwarded instruction word.
module idu_dec
  import idu_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [CPU_WIDTH-1:0] i_inst,
  input  logic [CPU_WIDTH-1:0] i_rs1,
  input  logic [CPU_WIDTH-1:0] i_rs2,
  output idu_bundle_t          o_dec
);
  logic [6:0]                w_opc;
  logic [2:0]                w_f3;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [CPU_WIDTH-1:0]      w_imm_i;
  logic [CPU_WIDTH-1:0]      w_imm_s;
  logic [CPU_WIDTH-1:0]      w_imm_u;
  logic [CPU_WIDTH-1:0]      w_sum_i;
  logic [CPU_WIDTH-1:0]      w_sum_s;
  logic                      w_writes_rd;

  assign w_opc   = i_inst[6:0];
  assign w_f3    = i_inst[14:12];
  assign w_rd    = i_inst[11:7];
  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_u = {i_inst[31:12], 12'b0};
  assign w_sum_i = i_rs1 + w_imm_i;
  assign w_sum_s = i_rs1 + w_imm_s;

  always_comb begin
    o_dec        = '0;
    o_dec.pc     = i_pc;
    o_dec.inst   = i_inst;
    o_dec.alu_op = ALU_ADD;
    o_dec.branch = BRAN_NONE;
    o_dec.jump   = JUMP_NONE;
    w_writes_rd  = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_writes_rd    = 1'b1;
        o_dec.alu_src1 = i_rs1;
        o_dec.alu_src2 = i_rs2;
        o_dec.alu_op   = alu_of_funct3(w_f3, i_inst[30]);
      end
      OPC_OPIMM: begin
        w_writes_rd    = 1'b1;
        o_dec.alu_src1 = i_rs1;
        o_dec.alu_src2 = (w_f3 == 3'b001 || w_f3 == 3'b101) ? {27'b0, i_inst[24:20]} : w_imm_i;
        // inst[30] is immediate data for ADDI, so only the shift-right form may use it
        o_dec.alu_op   = alu_of_funct3(w_f3, (w_f3 == 3'b101) & i_inst[30]);
      end
      OPC_LUI: begin
        w_writes_rd    = 1'b1;
        o_dec.alu_src2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_writes_rd    = 1'b1;
        o_dec.alu_src1 = i_pc;
        o_dec.alu_src2 = w_imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        w_writes_rd    = 1'b1;
        o_dec.alu_src1 = i_pc;
        o_dec.alu_src2 = 32'd4;
        o_dec.jump     = (w_opc == OPC_JAL) ? JUMP_JAL : JUMP_JALR;
      end
      OPC_BRANCH: begin
        o_dec.alu_src1 = i_rs1;
        o_dec.alu_src2 = i_rs2;
        case (w_f3)
          3'b000:  begin o_dec.branch = BRAN_BEQ;  o_dec.alu_op = ALU_EQU;  end
          3'b001:  begin o_dec.branch = BRAN_BNE;  o_dec.alu_op = ALU_EQU;  end
          3'b100:  begin o_dec.branch = BRAN_BLT;  o_dec.alu_op = ALU_SLT;  end
          3'b101:  begin o_dec.branch = BRAN_BGE;  o_dec.alu_op = ALU_SLT;  end
          3'b110:  begin o_dec.branch = BRAN_BLTU; o_dec.alu_op = ALU_SLTU; end
          3'b111:  begin o_dec.branch = BRAN_BGEU; o_dec.alu_op = ALU_SLTU; end
          default: o_dec.branch = BRAN_NONE;
        endcase
      end
      OPC_LOAD: begin
        w_writes_rd     = 1'b1;
        o_dec.mem_ren   = 1'b1;
        o_dec.mem2reg   = 1'b1;
        o_dec.mem_raddr = w_sum_i;
        o_dec.mem_op    = w_f3;
        o_dec.alu_src1  = i_rs1;
        o_dec.alu_src2  = w_imm_i;
      end
      OPC_STORE: begin
        o_dec.mem_wen   = 1'b1;
        o_dec.mem_waddr = w_sum_s;
        o_dec.mem_op    = w_f3;
        o_dec.alu_src1  = i_rs1;
        o_dec.alu_src2  = i_rs2;
      end
      default: o_dec.illegal = ILLEGAL_AS_NOP;
    endcase
    if (w_writes_rd) begin
      o_dec.reg_waddr = w_rd;
      o_dec.reg_wen   = (w_rd != '0);
    end
  end
endmodule

// File: rtl/idu.sv
// Decode stage: valid/ready intake from IFU, one-entry output register toward EXU,
// flush from branch/jump resolution overriding everything but reset.
module idu
  import idu_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           flush,
  input  logic                           ifu2idu_en,
  input  logic [CPU_WIDTH-1:0]           ifu2idu_pc,
  input  logic [CPU_WIDTH-1:0]           ifu2idu_inst,
  output logic                           idu_ready,
  output logic [REG_ADDR_WIDTH-1:0]      reg1_raddr,
  output logic [REG_ADDR_WIDTH-1:0]      reg2_raddr,
  input  logic [CPU_WIDTH-1:0]           reg1_rdata,
  input  logic [CPU_WIDTH-1:0]           reg2_rdata,
  input  logic                           exu_ready,
  output logic                           idu2exu_en,
  output logic [CPU_WIDTH-1:0]           idu2exu_pc,
  output logic [CPU_WIDTH-1:0]           idu2exu_inst,
  output logic [BRAN_WIDTH-1:0]          idu2exu_branch,
  output logic [JUMP_WIDTH-1:0]          idu2exu_jump,
  output logic                           idu2exu_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0]      idu2exu_reg_waddr,
  output logic                           idu2exu_mem_wen,
  output logic                           idu2exu_mem_ren,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] idu2exu_mem_waddr,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] idu2exu_mem_raddr,
  output logic                           idu2exu_mem2reg,
  output logic [MEM_OP_WIDTH-1:0]        idu2exu_mem_op,
  output logic [ALU_OP_WIDTH-1:0]        idu2exu_alu_op,
  output logic [CPU_WIDTH-1:0]           idu2exu_alu_src1,
  output logic [CPU_WIDTH-1:0]           idu2exu_alu_src2,
  output logic                           idu_illegal
);
  idu_bundle_t w_dec;
  idu_bundle_t r_bundle;
  logic        r_en;
  logic        w_accept;

  idu_dec #(.ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) u_dec (
    .i_pc   (ifu2idu_pc),
    .i_inst (ifu2idu_inst),
    .i_rs1  (reg1_rdata),
    .i_rs2  (reg2_rdata),
    .o_dec  (w_dec)
  );

  assign reg1_raddr = ifu2idu_inst[19:15];
  assign reg2_raddr = ifu2idu_inst[24:20];
  assign idu_ready  = enable & ~flush & (~r_en | exu_ready);
  assign w_accept   = ifu2idu_en & idu_ready;

  // Payload holds after a drain; only the valid bit tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_bundle <= '0;
    end else if (flush) begin
      r_en <= 1'b0;
    end else if (enable) begin
      if (w_accept) begin
        r_bundle <= w_dec;
        r_en     <= 1'b1;
      end else if (exu_ready) begin
        r_en <= 1'b0;
      end
    end
  end

  assign idu2exu_en        = r_en;
  assign idu2exu_pc        = r_bundle.pc;
  assign idu2exu_inst      = r_bundle.inst;
  assign idu2exu_branch    = r_bundle.branch;
  assign idu2exu_jump      = r_bundle.jump;
  assign idu2exu_reg_wen   = r_bundle.reg_wen;
  assign idu2exu_reg_waddr = r_bundle.reg_waddr;
  assign idu2exu_mem_wen   = r_bundle.mem_wen;
  assign idu2exu_mem_ren   = r_bundle.mem_ren;
  assign idu2exu_mem_waddr = r_bundle.mem_waddr;
  assign idu2exu_mem_raddr = r_bundle.mem_raddr;
  assign idu2exu_mem2reg   = r_bundle.mem2reg;
  assign idu2exu_mem_op    = r_bundle.mem_op;
  assign idu2exu_alu_op    = r_bundle.alu_op;
  assign idu2exu_alu_src1  = r_bundle.alu_src1;
  assign idu2exu_alu_src2  = r_bundle.alu_src2;
  assign idu_illegal       = r_bundle.illegal;
endmodule
